// File: rtl/dlx_bus_slave_responder.sv
`timescale 1ns/1ps
// dlx_bus_slave_responder
// Target-side responder for the DLX memory bus. Services master accesses from
// an internal word-addressed memory and returns a one-cycle active-low ACK_N
// after WAIT_CYCLES wait states.
// Ports:
//   CLK, RESET         : clock, synchronous active-high reset
//   AS_N, WR_N         : address strobe (active low), direction (0 = write)
//   ADDR, DIN          : word address and write data from the master
//   DOUT               : read data, held until the next read completes
//   ACK_N              : transfer acknowledge, low for one cycle per transfer
//   BUSY, STATE        : not-idle flag and debug view of the FSM state
//   TXN_CNT            : number of acknowledged transfers (wraps)
module dlx_bus_slave_responder #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              AS_N,
    input  logic              WR_N,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] DOUT,
    output logic              ACK_N,
    output logic              BUSY,
    output logic [1:0]        STATE,
    output logic [15:0]       TXN_CNT
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_ACK     = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic [1:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] din_q,    din_d;
    logic              wr_n_q,   wr_n_d;
    logic [DATA_W-1:0] dout_q,   dout_d;
    logic [15:0]       txn_q,    txn_d;

    // Access attributes used on ACK entry: live inputs when entering straight
    // from IDLE (zero-wait build), latched copies otherwise.
    logic              enter_ack;
    logic              mem_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_din;
    logic              acc_wr_n;

    // Next-state, latch and memory-access decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        din_d     = din_q;
        wr_n_d    = wr_n_q;
        dout_d    = dout_q;
        txn_d     = txn_q;
        enter_ack = 1'b0;
        mem_we    = 1'b0;
        acc_addr  = addr_q;
        acc_din   = din_q;
        acc_wr_n  = wr_n_q;

        case (state_q)
            S_IDLE: begin
                if (!AS_N) begin
                    addr_d   = ADDR;
                    din_d    = DIN;
                    wr_n_d   = WR_N;
                    acc_addr = ADDR;
                    acc_din  = DIN;
                    acc_wr_n = WR_N;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = S_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (AS_N) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d   = S_ACK;
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACK: begin
                state_d = S_RELEASE;
            end
            default: begin
                // Hold until the strobe drops so one long strobe counts once
                if (AS_N) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        if (enter_ack) begin
            txn_d = txn_q + 16'd1;
            if (acc_wr_n) begin
                dout_d = mem[acc_addr];
            end else begin
                mem_we = 1'b1;
            end
        end
    end

    // State and attribute registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            wr_n_q  <= 1'b0;
            dout_q  <= '0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wr_n_q  <= wr_n_d;
            dout_q  <= dout_d;
            txn_q   <= txn_d;
        end
    end

    // Memory write; contents survive reset but a reset edge drops the write
    always_ff @(posedge CLK) begin
        if (!RESET && mem_we) begin
            mem[acc_addr] <= acc_din;
        end
    end

    assign DOUT    = dout_q;
    assign ACK_N   = (state_q != S_ACK);
    assign BUSY    = (state_q != S_IDLE);
    assign STATE   = state_q;
    assign TXN_CNT = txn_q;

endmodule

// File: tb/tb_dlx_bus_slave_responder.sv
`timescale 1ns/1ps
module tb_dlx_bus_slave_responder;

    logic        CLK   = 1'b0;
    logic        RESET = 1'b1;
    always #5 CLK = ~CLK;

    // sel = 0 targets the WAIT_CYCLES=2 instance, sel = 1 the zero-wait one
    logic        sel   = 1'b0;
    logic        as_n  = 1'b1;
    logic        wr_n  = 1'b1;
    logic [4:0]  addr  = '0;
    logic [31:0] din   = '0;

    logic        as_n2, as_n0;
    logic [31:0] dout2, dout0;
    logic        ack2, ack0, busy2, busy0;
    logic [1:0]  st2, st0;
    logic [15:0] cnt2, cnt0;

    assign as_n2 = sel ? 1'b1 : as_n;
    assign as_n0 = sel ? as_n : 1'b1;

    dlx_bus_slave_responder #(.ADDR_W(5), .DATA_W(32), .WAIT_CYCLES(2)) dut (
        .CLK(CLK), .RESET(RESET), .AS_N(as_n2), .WR_N(wr_n), .ADDR(addr), .DIN(din),
        .DOUT(dout2), .ACK_N(ack2), .BUSY(busy2), .STATE(st2), .TXN_CNT(cnt2));

    dlx_bus_slave_responder #(.ADDR_W(5), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .AS_N(as_n0), .WR_N(wr_n), .ADDR(addr), .DIN(din),
        .DOUT(dout0), .ACK_N(ack0), .BUSY(busy0), .STATE(st0), .TXN_CNT(cnt0));

    logic [31:0] o_dout;
    logic        o_ack, o_busy;
    logic [1:0]  o_st;
    logic [15:0] o_cnt;
    assign o_dout = sel ? dout0 : dout2;
    assign o_ack  = sel ? ack0  : ack2;
    assign o_busy = sel ? busy0 : busy2;
    assign o_st   = sel ? st0   : st2;
    assign o_cnt  = sel ? cnt0  : cnt2;

    int checks = 0;
    int errors = 0;

    // Reference model: per-instance memory image, last read data, transfer count
    logic [31:0] mmem [2][32];
    logic [31:0] mdout [2];
    logic [15:0] mtxn [2];

    function automatic int lat();
        return sel ? 0 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        int s = sel ? 1 : 0;
        chk({tag, "_ack"},   32'(o_ack),  32'd1);
        chk({tag, "_busy"},  32'(o_busy), 32'd0);
        chk({tag, "_state"}, 32'(o_st),   32'd0);
        chk({tag, "_txn"},   32'(o_cnt),  32'(mtxn[s]));
        chk({tag, "_dout"},  o_dout,      mdout[s]);
    endtask

    // Full transfer; hold = extra cycles the strobe stays low in RELEASE
    task automatic txn(input bit wr, input logic [4:0] a, input logic [31:0] d, input int hold);
        int w = lat();
        int s = sel ? 1 : 0;
        as_n = 1'b0; wr_n = ~wr; addr = a; din = d;
        for (int k = 0; k <= w; k++) begin
            step();
            // attributes after the sampling edge must be ignored
            wr_n = 1'($urandom); addr = 5'($urandom); din = $urandom;
            if (k < w) begin
                chk("wait_ack",   32'(o_ack),  32'd1);
                chk("wait_state", 32'(o_st),   32'd1);
                chk("wait_busy",  32'(o_busy), 32'd1);
            end
        end
        if (wr) mmem[s][a] = d;
        else    mdout[s] = mmem[s][a];
        mtxn[s] = mtxn[s] + 16'd1;
        chk("ack_low",   32'(o_ack), 32'd0);
        chk("ack_state", 32'(o_st),  32'd2);
        chk("ack_txn",   32'(o_cnt), 32'(mtxn[s]));
        chk("ack_dout",  o_dout,     mdout[s]);
        for (int h = 0; h <= hold; h++) begin
            step();
            chk("rel_ack",   32'(o_ack), 32'd1);
            chk("rel_state", 32'(o_st),  32'd3);
            chk("rel_dout",  o_dout,     mdout[s]);
        end
        as_n = 1'b1;
        step();
        chk_idle("post_txn");
    endtask

    // Strobe dropped after ac+1 sampling edges, before ACK would be reached
    task automatic abort_txn(input bit wr, input logic [4:0] a, input logic [31:0] d, input int ac);
        as_n = 1'b0; wr_n = ~wr; addr = a; din = d;
        for (int k = 0; k <= ac; k++) begin
            step();
            chk("abort_ack",   32'(o_ack), 32'd1);
            chk("abort_state", 32'(o_st),  32'd1);
        end
        as_n = 1'b1;
        step();
        chk_idle("abort_idle");
    endtask

    task automatic reset_pulse();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        as_n  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mtxn[i]  = '0;
            mdout[i] = '0;
        end
    endtask

    initial begin
        bit          wr;
        logic [4:0]  a;
        logic [31:0] d;

        for (int i = 0; i < 2; i++) begin
            mtxn[i]  = '0;
            mdout[i] = '0;
        end
        step();
        step();
        RESET = 1'b0;
        sel = 1'b0; chk_idle("reset2");
        sel = 1'b1; chk_idle("reset0");
        sel = 1'b0;

        // Give every location a known value, then restart the counter
        for (int i = 0; i < 32; i++) txn(1'b1, 5'(i), $urandom | 32'h100, 0);
        reset_pulse();
        chk_idle("reset_from_idle");

        txn(1'b1, 5'd5, 32'hDEADBEEF, 0);
        chk("txn_after_first", 32'(o_cnt), 32'd1);
        txn(1'b0, 5'd5, 32'h0, 0);
        chk("readback", o_dout, 32'hDEADBEEF);
        txn(1'b1, 5'd6, 32'h12345678, 0);
        chk("dout_hold_after_write", o_dout, 32'hDEADBEEF);

        abort_txn(1'b1, 5'd7, 32'hAAAA5555, 1);
        txn(1'b0, 5'd7, 32'h0, 0);

        txn(1'b0, 5'd6, 32'h0, 4);
        chk("long_strobe_read", o_dout, 32'h12345678);

        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom);
            a  = 5'($urandom);
            d  = $urandom | 32'h100;
            if ($urandom_range(0, 4) == 0) abort_txn(wr, a, d, $urandom_range(0, 1));
            else                           txn(wr, a, d, $urandom_range(0, 3));
        end

        // Reset while the write to address 3 is waiting
        as_n = 1'b0; wr_n = 1'b0; addr = 5'd3; din = 32'h1;
        step();
        chk("rst_wait_state", 32'(o_st), 32'd1);
        reset_pulse();
        chk_idle("rst_mid");
        txn(1'b0, 5'd3, 32'h0, 0);
        chk("rst_dropped_write", 32'(o_dout == 32'h1), 32'd0);

        // Zero-wait instance
        sel = 1'b1;
        for (int i = 0; i < 8; i++) txn(1'b1, 5'(i), $urandom, 0);
        txn(1'b0, 5'd2, 32'h0, 0);
        txn(1'b0, 5'd5, 32'h0, 0);
        for (int n = 0; n < 20; n++) begin
            txn(1'($urandom), 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
